// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared types and constants for the dehaze output-frame writer.
//   IMG_W_DEF / IMG_H_DEF : default frame geometry (640x480)
//   ADDR_W                : linear BRAM address width
//   rgb_t                 : packed {r,g,b} pixel
//   wr_state_e            : writer FSM states
//   cnt_w()               : counter width for a modulus, minimum 1 bit
package dehaze_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned ADDR_W    = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dehaze_xy_counter.sv
// dehaze_xy_counter: raster column/row/linear-address tracker.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to pixel (0,0), address 0
//   en         : advance one pixel
//   col, row   : current pixel position (registered)
//   addr       : current linear address row*IMG_W+col (registered)
//   last_c     : current pixel is the final pixel of the frame
module dehaze_xy_counter
  import dehaze_pkg::*;
#(
  parameter  int unsigned IMG_W = IMG_W_DEF,
  parameter  int unsigned IMG_H = IMG_H_DEF,
  localparam int unsigned COL_W = cnt_w(IMG_W),
  localparam int unsigned ROW_W = cnt_w(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_end_c;
  logic              row_end_c;

  assign col_end_c = (col_q == COL_W'(IMG_W - 1));
  assign row_end_c = (row_q == ROW_W'(IMG_H - 1));
  assign last_c    = col_end_c && row_end_c;

  // Address is carried incrementally rather than multiplied out.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en) begin
      if (col_end_c) begin
        col_d = '0;
        row_d = row_end_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      addr_d = last_c ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/dehaze_frame_writer.sv
// dehaze_frame_writer: captures one restored frame into the output BRAM.
//   Drops the first PIPE_LAT valid beats (pipeline fill), then writes IMG_W*IMG_H
//   pixels in raster order with one cycle of latency.
//   Inputs : clk, rst_n (async active-low), start, pix_valid, pix_r/g/b
//   Outputs: wr_en, wr_addr[18:0], wr_data[23:0] {R,G,B}, busy, frame_done
//   Build option: DEHAZE_BORDER_ZERO_EN writes frame-border pixels as zero.
module dehaze_frame_writer
  import dehaze_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned PIPE_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned COL_W  = cnt_w(IMG_W);
  localparam int unsigned ROW_W  = cnt_w(IMG_H);
  localparam int unsigned FILL_W = cnt_w(PIPE_LAT);
`ifdef DEHAZE_BORDER_ZERO_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  wr_state_e         state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  rgb_t              wr_data_q, wr_data_d;

  logic              cnt_clr_c;
  logic              cnt_en_c;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              last_c;
  logic              border_c;
  rgb_t              pix_c;

  dehaze_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .col    (col),
    .row    (row),
    .addr   (addr),
    .last_c (last_c)
  );

  // 3x3 neighbourhood is incomplete on the frame border; blank it when enabled.
  assign border_c = BORDER_EN &&
                    ((row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                     (col == '0) || (col == COL_W'(IMG_W - 1)));

  always_comb begin
    pix_c = '{r: pix_r, g: pix_g, b: pix_b};
    if (border_c) pix_c = '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    busy_d       = busy_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cnt_clr_c    = 1'b0;
    cnt_en_c     = 1'b0;
    case (state_q)
      // pix_valid coincident with start is not counted.
      ST_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          fill_d    = '0;
          cnt_clr_c = 1'b1;
          state_d   = (PIPE_LAT == 0) ? ST_WRITE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (pix_valid) begin
          if (fill_q == FILL_W'(PIPE_LAT - 1)) begin
            fill_d  = '0;
            state_d = ST_WRITE;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (pix_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr;
          wr_data_d = pix_c;
          cnt_en_c  = 1'b1;
          if (last_c) begin
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fill_q       <= '0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dehaze_frame_writer.sv
// Directed bench for dehaze_frame_writer on a 4x3 frame (PIPE_LAT=2), plus a
// PIPE_LAT=0 instance sharing the same stimulus.
module tb_dehaze_frame_writer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int LAT = 2;
  localparam int NPX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;

  logic        wr_en, busy, frame_done;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en0, busy0, frame_done0;
  logic [18:0] wr_addr0;
  logic [23:0] wr_data0;

  dehaze_frame_writer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  dehaze_frame_writer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .frame_done(frame_done0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Capture of one run of the main DUT
  int          got_addr[$];
  logic [23:0] got_data[$];
  bit          got_done[$];
  int          bad_en;
  bit          timed_out;
  logic        busy_first, busy_after;
  logic [45:0] rst_snap;

  // Expected written pixel at linear address a carrying input value val
  function automatic logic [23:0] exp_pix(input int a, input int val);
    int r;
    int c;
    r = a / W;
    c = a % W;
`ifdef DEHAZE_BORDER_ZERO_EN
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 24'h000000;
`else
    if (r < 0 || c < 0) return 24'hxxxxxx;
`endif
    return 24'(val);
  endfunction

  // Drive one frame on the main DUT and capture every write.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_frame(input int n_beats, input bit toggle, input int start_at,
                           input int rst_at, input bit start_with_valid);
    int b;
    bit prev_v;
    bit seen_done;
    bit fired;
    got_addr.delete(); got_data.delete(); got_done.delete();
    bad_en = 0; timed_out = 1'b1; busy_first = 1'b0; busy_after = 1'b1;
    b = 0; prev_v = 1'b0; seen_done = 1'b0; fired = 1'b0;
    @(negedge clk);
    start = 1'b1;
    pix_valid = start_with_valid;
    {pix_r, pix_g, pix_b} = 24'hABCDEF;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c == 0) busy_first = busy;
      if (wr_en) begin
        got_addr.push_back(int'(wr_addr));
        got_data.push_back(wr_data);
        got_done.push_back(frame_done);
        if (!prev_v) bad_en++;
      end else if (frame_done) begin
        bad_en++;
      end
      if (seen_done) begin
        busy_after = busy;
        timed_out  = 1'b0;
        break;
      end
      if (frame_done) seen_done = 1'b1;
      if (rst_at >= 0 && got_addr.size() == rst_at) begin
        rst_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        rst_snap  = {wr_en, wr_addr, wr_data, busy, frame_done};
        timed_out = 1'b0;
        break;
      end
      start = (start_at >= 0 && !fired && got_addr.size() == start_at);
      if (start) fired = 1'b1;
      if (b < n_beats && !(toggle && (c % 2) == 1)) begin
        pix_valid = 1'b1;
        {pix_r, pix_g, pix_b} = 24'(b);
        b++;
      end else begin
        pix_valid = 1'b0;
      end
      prev_v = pix_valid;
      @(negedge clk);
    end
    start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done} !== 46'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, want 0", {wr_en, wr_addr, wr_data, busy, frame_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wr_en, busy, frame_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_idle: wr_en/busy/frame_done=%b, want 000", {wr_en, busy, frame_done});
    end
  endtask

  task automatic test_idle_ignore();
    int act;
    act = 0;
    for (int c = 0; c < 6; c++) begin
      pix_valid = 1'b1;
      {pix_r, pix_g, pix_b} = 24'(c);
      @(negedge clk);
      if (wr_en || busy || frame_done) act++;
    end
    pix_valid = 1'b0;
    n_checks++;
    if (act != 0) begin
      n_errors++;
      $display("FAIL idle_ignore: %0d active cycles, want 0", act);
    end
  endtask

  task automatic test_continuous();
    run_frame(NPX + LAT, 1'b0, -1, -1, 1'b0);
    n_checks++;
    if (timed_out) begin n_errors++; $display("FAIL cont_timeout: frame_done not seen, want seen"); end
    n_checks++;
    if (got_addr.size() != NPX) begin
      n_errors++; $display("FAIL cont_count: %0d writes, want %0d", got_addr.size(), NPX);
    end
    foreach (got_addr[i]) begin
      n_checks++;
      if (got_addr[i] != i || got_data[i] !== exp_pix(i, i + LAT) || got_done[i] != (i == NPX - 1)) begin
        n_errors++;
        $display("FAIL cont_write%0d: addr=%0d data=%h done=%0d, want addr=%0d data=%h done=%0d",
                 i, got_addr[i], got_data[i], got_done[i], i, exp_pix(i, i + LAT), (i == NPX - 1));
      end
    end
    n_checks++;
    if (bad_en != 0 || busy_first !== 1'b1 || busy_after !== 1'b0) begin
      n_errors++;
      $display("FAIL cont_ctrl: bad_en=%0d busy_first=%b busy_after=%b, want 0/1/0",
               bad_en, busy_first, busy_after);
    end
  endtask

  task automatic test_stall();
    run_frame(NPX + LAT, 1'b1, -1, -1, 1'b0);
    n_checks++;
    if (timed_out || got_addr.size() != NPX) begin
      n_errors++;
      $display("FAIL stall_count: timeout=%0d writes=%0d, want 0/%0d", timed_out, got_addr.size(), NPX);
    end
    foreach (got_addr[i]) begin
      n_checks++;
      if (got_addr[i] != i || got_data[i] !== exp_pix(i, i + LAT) || got_done[i] != (i == NPX - 1)) begin
        n_errors++;
        $display("FAIL stall_write%0d: addr=%0d data=%h done=%0d, want addr=%0d data=%h",
                 i, got_addr[i], got_data[i], got_done[i], i, exp_pix(i, i + LAT));
      end
    end
    n_checks++;
    if (bad_en != 0 || busy_after !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_wr_en: stray writes=%0d busy_after=%b, want 0/0", bad_en, busy_after);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(NPX + LAT, 1'b0, -1, 5, 1'b0);
    n_checks++;
    if (timed_out || got_addr.size() != 5 || got_done[4] != 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_reach: timeout=%0d writes=%0d, want 0/5 without done", timed_out, got_addr.size());
    end
    n_checks++;
    if (rst_snap !== 46'd0) begin
      n_errors++; $display("FAIL rst_mid_outputs: got %h, want 0", rst_snap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(NPX + LAT, 1'b0, -1, -1, 1'b0);
    n_checks++;
    if (timed_out || got_addr.size() != NPX || got_addr[0] != 0 || got_data[0] !== exp_pix(0, LAT)
        || got_addr[NPX-1] != NPX - 1 || got_done[NPX-1] != 1'b1) begin
      n_errors++;
      $display("FAIL rst_restart: writes=%0d first_addr=%0d first_data=%h, want %0d/0/%h",
               got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1,
               (got_data.size() > 0) ? got_data[0] : 24'hx, NPX, exp_pix(0, LAT));
    end
  endtask

  task automatic test_start_ignored();
    run_frame(NPX + LAT, 1'b0, 6, -1, 1'b0);
    n_checks++;
    if (timed_out || got_addr.size() != NPX) begin
      n_errors++;
      $display("FAIL busy_start_count: timeout=%0d writes=%0d, want 0/%0d", timed_out, got_addr.size(), NPX);
    end
    foreach (got_addr[i]) begin
      n_checks++;
      if (got_addr[i] != i || got_data[i] !== exp_pix(i, i + LAT) || got_done[i] != (i == NPX - 1)) begin
        n_errors++;
        $display("FAIL busy_start_write%0d: addr=%0d data=%h done=%0d, want addr=%0d data=%h",
                 i, got_addr[i], got_data[i], got_done[i], i, exp_pix(i, i + LAT));
      end
    end
  endtask

  task automatic test_start_with_valid();
    run_frame(NPX + LAT, 1'b0, -1, -1, 1'b1);
    n_checks++;
    if (timed_out || got_addr.size() != NPX || got_data[0] !== exp_pix(0, LAT)
        || got_data[NPX-1] !== exp_pix(NPX - 1, NPX - 1 + LAT)) begin
      n_errors++;
      $display("FAIL start_valid: writes=%0d first_data=%h, want %0d/%h",
               got_addr.size(), (got_data.size() > 0) ? got_data[0] : 24'hx, NPX, exp_pix(0, LAT));
    end
  endtask

  task automatic test_pipe_lat0();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wr_en0) begin
        n_checks++;
        if (wr_addr0 !== 19'(n) || wr_data0 !== exp_pix(n, n) || frame_done0 !== (n == NPX - 1)) begin
          n_errors++;
          $display("FAIL lat0_write%0d: addr=%0d data=%h done=%b, want addr=%0d data=%h",
                   n, wr_addr0, wr_data0, frame_done0, n, exp_pix(n, n));
        end
        n++;
      end
      if (seen) begin
        n_checks++;
        if (busy0 !== 1'b0) begin n_errors++; $display("FAIL lat0_busy: busy=%b, want 0", busy0); end
        break;
      end
      if (frame_done0) seen = 1'b1;
      if (c < NPX) begin
        pix_valid = 1'b1;
        {pix_r, pix_g, pix_b} = 24'(c);
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    n_checks++;
    if (n != NPX || !seen) begin
      n_errors++; $display("FAIL lat0_count: writes=%0d done_seen=%0d, want %0d/1", n, seen, NPX);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_continuous();
    test_stall();
    test_reset_mid_frame();
    test_start_ignored();
    test_start_with_valid();
    test_pipe_lat0();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dehaze_frame_writer.md
DEHAZE_FRAME_WRITER -- requirements
Module: dehaze_frame_writer

Interface
REQ-001 Parameter IMG_W, default 640, meaning: pixels per row.
REQ-002 Parameter IMG_H, default 480, meaning: rows per frame.
REQ-003 Parameter PIPE_LAT, default 8, meaning: leading valid beats discarded as pipeline-fill garbage.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse arming capture of one frame.
REQ-007 pix_valid  in  1  restoration-stage output pixel valid this cycle.
REQ-008 pix_r, pix_g, pix_b  in  8 each  dehazed pixel from scene restoration.
REQ-009 wr_en  out  1  output-frame BRAM write enable.
REQ-010 wr_addr  out  19  linear BRAM address, row*IMG_W+col.
REQ-011 wr_data  out  24  {R,G,B} written pixel.
REQ-012 busy  out  1  high from accepted start until frame_done.
REQ-013 frame_done  out  1  one-cycle pulse on the final write.

Function
REQ-014 States SHALL be IDLE, FILL, WRITE, DONE.
REQ-015 IDLE->FILL on start; IDLE->WRITE directly when PIPE_LAT==0.
REQ-016 FILL SHALL count pix_valid beats without writing; move to WRITE after the PIPE_LAT-th beat.
REQ-017 WRITE SHALL, per pix_valid beat, register wr_en=1, wr_data={pix_r,pix_g,pix_b}, wr_addr=current address; latency exactly 1 cycle.
REQ-018 pix_valid low SHALL stall counters and drive wr_en=0; no address advance.
REQ-019 col wraps IMG_W-1->0 with row+1; address increments by 1 per write, no gaps.
REQ-020 On write of row IMG_H-1, col IMG_W-1: frame_done asserts same cycle as that wr_en, state->DONE.
REQ-021 DONE SHALL last one cycle, drop busy, return to IDLE.
REQ-022 start while busy SHALL be ignored; pix_valid in IDLE/DONE SHALL be ignored.
REQ-023 start and pix_valid same cycle in IDLE: that beat is not counted.
REQ-024 Address arithmetic 19 bits unsigned; IMG_W*IMG_H must be <=2^19 (640x480 fits).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counters 0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0.
REQ-026 Reset mid-frame SHALL abandon the frame; no frame_done; next start restarts at address 0.

Configuration
REQ-027 Macro DEHAZE_BORDER_ZERO_EN defined: pixels with row 0, row IMG_H-1, col 0 or col IMG_W-1 SHALL be written as 24'h000000 (3x3 window invalid there).
REQ-028 Macro undefined: all pixels written unmodified; address/timing identical in both builds.

Structure
REQ-029 Package dehaze_pkg SHALL hold IMG_W/IMG_H defaults, ADDR_W=19, rgb_t packed {r,g,b} typedef, writer state enum.
REQ-030 One sub-module dehaze_xy_counter (row/col/addr with enable, clear, last flag) SHALL be instantiated.

Verification (IMG_W=4, IMG_H=3, PIPE_LAT=2 unless stated)
REQ-031 start, 14 continuous valids with data=index -> beats 0,1 dropped; 12 writes addr 0..11 data 2..13; frame_done with addr 11.
REQ-032 Same, pix_valid toggling 1/0 -> identical addr/data sequence, wr_en only on valid+1 cycles.
REQ-033 rst_n low after 5th write -> outputs 0 at once; new start -> first write addr 0.
REQ-034 start pulsed at write 6 -> ignored, sequence and frame_done unchanged.
REQ-035 DEHAZE_BORDER_ZERO_EN, data 24'hFFFFFF -> addr 5,6 written FFFFFF, all other 10 addresses 000000.
REQ-036 PIPE_LAT=0, 640x480 -> first write addr 0, last addr 307199 with frame_done, busy low next cycle.
